add_seq_ctrl: RTL
=================

// Module: add_seq_ctrl
// PURPOSE
//  Sequencer that performs WORDS*128-bit add/subtract by time-multiplexing one
//  add_128 instance, one 128-bit limb per cycle, chaining the carry through a
//  register. Serves the Karatsuba recombination stage, where wide partial-product
//  sums exceed 128 bits. Single-operation start/done handshake.
// PARAMETERS
//  WORDS  4    number of 128-bit limbs per operand (>=1); operand width N=WORDS*128
//  LW     128  limb width; fixed at 128 (width of add_128); other values illegal
// PORTS
//  clk    in   1    clock, all state updates on rising edge
//  rst    in   1    synchronous reset, active-high
//  start  in   1    request; accepted only when ready=1
//  op     in   1    0: a+b+cin   1: a-b (a + ~b + 1, cin ignored); sampled on accept
//  cin    in   1    carry-in for add; sampled on accept
//  a      in   N    operand A; sampled on accept
//  b      in   N    operand B; sampled on accept
//  ready  out  1    1 in IDLE only
//  done   out  1    one-cycle pulse, result valid
//  sum    out  N    result, limb i at [128*i+127:128*i]
//  cout   out  1    final carry; for op=1, 1 = no borrow (a>=b)
// BEHAVIOUR
//  Clock/reset: one clock clk; reset rst is synchronous and active-high.
//  - Reset values (first clk edge with rst=1): state=IDLE, ready=1, done=0,
//    sum=0, cout=0, limb index=0, carry reg=0.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: ready=1. On start=1: a_reg<=a; b_reg<=op?~b:b; carry<=op?1:cin;
//      idx<=0; sum<=0; go to RUN. start=0: stay.
//    RUN: add_128 combinational inputs = a_reg limb idx, b_reg limb idx, carry.
//      Each cycle: sum limb idx <= adder sum; carry <= adder coin; idx<=idx+1.
//      When idx==WORDS-1: cout <= adder coin, go to DONE (idx not incremented
//      past WORDS-1). WORDS=1 gives exactly one RUN cycle.
//    DONE: done=1 for this cycle only; unconditionally go to IDLE.
//  - Latency: start accepted at edge T0; RUN occupies WORDS cycles; done=1 in
//    cycle WORDS+1 after acceptance. Throughput: one op per WORDS+2 cycles.
//  - start while ready=0 (RUN or DONE) is ignored, not queued.
//  - Inputs a, b, op, cin are don't-care after acceptance; changes mid-run do not
//    affect the result.
//  - sum and cout hold their final values from done until the next accepted start
//    (cleared to 0 at that acceptance).
//  - Result is modulo 2^N; overflow is reported only via cout.
//  - rst mid-operation (RUN or DONE): abort, all reset values next cycle, no done.
//  - rst has priority over start in the same cycle.
//  - idx width = max(1, clog2(WORDS)); no wrap reachable.
// TESTING (WORDS=4, N=512)
//  1 add a=2^512-1, b=1, cin=0 -> sum=0, cout=1, done exactly 5 cycles after accept.
//  2 add a=2^128-1, b=1, cin=0 -> sum=2^128 (limb1=1, others 0), cout=0 (carry chain).
//  3 add a=0, b=0, cin=1 -> sum=1, cout=0; sub a=0, b=1 -> sum=2^512-1, cout=0.
//  4 sub a=b=0x1234_5678 repeated in every limb -> sum=0, cout=1.
//  5 start during RUN with new operands, and a/b toggled mid-run -> ignored;
//    result is that of first op; exactly one done pulse.
//  6 rst=1 during 2nd RUN cycle -> next cycle ready=1, sum=0, cout=0; no done pulse;
//    subsequent op (case 1) completes correctly.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// Multi-limb add/subtract sequencer: one add_128 reused for every 128-bit limb.
// Ports: clk, rst (sync, active-high), start/ready/done handshake, op, cin, a, b, sum, cout.
module add_128 (
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic         cin,
    output logic [127:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {128'd0, cin};
endmodule

module add_seq_ctrl #(
    parameter int WORDS = 4,
    parameter int LW    = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic                cin,
    input  logic [WORDS*LW-1:0] a,
    input  logic [WORDS*LW-1:0] b,
    output logic                ready,
    output logic                done,
    output logic [WORDS*LW-1:0] sum,
    output logic                cout
);
    localparam int N  = WORDS * LW;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic          carry;
    logic [IW-1:0] idx;
    logic [127:0]  limb_s;
    logic          limb_c;
    logic          last;

    assign last = (idx == LAST);

    add_128 u_add (
        .a    (a_reg[idx*LW +: LW]),
        .b    (b_reg[idx*LW +: LW]),
        .cin  (carry),
        .s    (limb_s),
        .cout (limb_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Subtract is a + ~b + 1: invert b and force carry-in at accept time.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= op ? ~b : b;
                        carry <= op ? 1'b1 : cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                    end
                end
                RUN: begin
                    sum[idx*LW +: LW] <= limb_s;
                    carry             <= limb_c;
                    if (last) cout <= limb_c;
                    else      idx  <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
